// File: rtl/ucore_bcd_pkg.sv
// ucore_bcd_pkg
//   Shared constants and FSM encoding for the binary-to-BCD converter.
//   W_BIN_DEF / N_DIG_DEF : default operand width and BCD digit count
//   CNT_W                 : iteration counter width (counts W_BIN-1 .. 0)
//   DIG_W                 : width of one BCD digit
//   NDIG_W                : width of the significant-digit count output
package ucore_bcd_pkg;

  localparam int W_BIN_DEF = 64;
  localparam int N_DIG_DEF = 20;
  localparam int CNT_W     = 6;
  localparam int DIG_W     = 4;
  localparam int NDIG_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } bcd_state_e;

endpackage

// File: rtl/ucore_bcd_digit_adj.sv
// ucore_bcd_digit_adj
//   Combinational double-dabble correction cell: a BCD digit of 5 or more
//   gets +3 so that the following left shift carries correctly into the
//   next decimal digit. No carry leaves the cell.
//   i_dig : BCD digit before correction
//   o_dig : corrected digit
module ucore_bcd_digit_adj
  import ucore_bcd_pkg::*;
(
  input  logic [DIG_W-1:0] i_dig,
  output logic [DIG_W-1:0] o_dig
);

  assign o_dig = (i_dig >= DIG_W'(5)) ? (i_dig + DIG_W'(3)) : i_dig;

endmodule

// File: rtl/ucore_bcd_conv.sv
// ucore_bcd_conv
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
//   Accepts an operand in IDLE, runs W_BIN iterations, then presents the
//   packed BCD result on a ready/valid output.
//   Ports:
//     clk         : sole clock, rising edge
//     aresetn     : synchronous active-low reset
//     in_valid    : operand present
//     in_result   : binary operand [W_BIN]
//     in_ready    : idle, operand can be accepted
//     out_valid   : out_bcd holds a completed conversion
//     out_ready   : consumer accepts out_bcd
//     out_bcd     : packed BCD [4*N_DIG], digit 0 in [3:0]
//     out_ndigits : significant digit count 1..N_DIG (only when
//                   UCORE_BCD_NDIGITS_EN is defined)
//
//   state | meaning
//   ------+------------------------------------------------
//   IDLE  | in_ready=1, waiting for an operand
//   CONV  | one add-3 + shift iteration per cycle
//   DONE  | out_valid=1, out_bcd stable until out_ready
module ucore_bcd_conv
  import ucore_bcd_pkg::*;
#(
  parameter int W_BIN = W_BIN_DEF,
  parameter int N_DIG = N_DIG_DEF
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   in_valid,
  input  logic [W_BIN-1:0]       in_result,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DIG_W*N_DIG-1:0] out_bcd
`ifdef UCORE_BCD_NDIGITS_EN
  ,
  output logic [NDIG_W-1:0]      out_ndigits
`endif
);

  localparam int W_BCD = DIG_W * N_DIG;

  bcd_state_e         r_state;
  bcd_state_e         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [W_BIN-1:0]   r_bin;
  logic [W_BCD-1:0]   r_bcd;
  logic [W_BCD-1:0]   w_adj;
  logic [W_BCD-1:0]   w_bcd_nxt;
  logic [W_BIN-1:0]   w_bin_nxt;
  logic               w_accept;
  logic               w_last;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign out_bcd   = r_bcd;
  assign w_accept  = in_valid && (r_state == ST_IDLE);
  assign w_last    = (r_state == ST_CONV) && (r_cnt == '0);

  for (genvar g = 0; g < N_DIG; g++) begin : g_adj
    ucore_bcd_digit_adj u_adj (
      .i_dig (r_bcd[g*DIG_W +: DIG_W]),
      .o_dig (w_adj[g*DIG_W +: DIG_W])
    );
  end

  // One iteration: corrected BCD and binary shifted left as a single register.
  assign w_bcd_nxt = {w_adj[W_BCD-2:0], r_bin[W_BIN-1]};
  assign w_bin_nxt = {r_bin[W_BIN-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (in_valid)  w_state_nxt = ST_CONV;
      ST_CONV: if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_bcd <= '0;
      r_bin <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_bin <= in_result;
      r_bcd <= '0;
      r_cnt <= CNT_W'(W_BIN - 1);
    end else if (r_state == ST_CONV) begin
      r_bcd <= w_bcd_nxt;
      r_bin <= w_bin_nxt;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

`ifdef UCORE_BCD_NDIGITS_EN
  logic [NDIG_W-1:0] r_ndig;
  logic [NDIG_W-1:0] w_ndig;

  // Highest nonzero digit wins; an all-zero result still reports one digit.
  always_comb begin
    w_ndig = NDIG_W'(1);
    for (int i = 0; i < N_DIG; i++) begin
      if (w_bcd_nxt[i*DIG_W +: DIG_W] != '0) w_ndig = NDIG_W'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn)    r_ndig <= NDIG_W'(1);
    else if (w_last) r_ndig <= w_ndig;
  end

  assign out_ndigits = r_ndig;
`endif

endmodule

// File: doc/ucore_bcd_conv.md
# ucore_bcd_conv

Sequential binary-to-BCD converter that sits directly downstream of `ucore_main`. It accepts the 64-bit Fibonacci `result` when the core raises `done`, and converts it to 20 packed BCD digits using shift-and-add-3 (double dabble), one bit per cycle. A ready/valid handshake on the output feeds the display/log stage.

## Interface
- `W_BIN`, default 64: binary operand width; fixed by the `ucore_main` result width.
- `N_DIG`, default 20: BCD digits; ceil(W_BIN·log10 2) = 20 for 64 bits.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `aresetn` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid` in 1: operand present; driven from `ucore_main.done`.
- `in_result` in W_BIN: binary operand; driven from `ucore_main.result`.
- `in_ready` out 1: converter idle and able to accept an operand.
- `out_valid` out 1: `out_bcd` holds a completed conversion.
- `out_ready` in 1: consumer accepts `out_bcd`.
- `out_bcd` out 4·N_DIG: packed BCD; digit 0 (units) is in bits [3:0].
- `out_ndigits` out 5: significant digit count, 1..20. Present only with `UCORE_BCD_NDIGITS_EN`.

## Operation
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: load the shift register with `in_result`, clear the BCD accumulator, set the bit counter to 63, and go to CONV.
- CONV:
  - Each cycle, every BCD digit ≥5 gets +3.
  - The {BCD, bin} register is then shifted left by 1.
  - The counter decrements; after the iteration with counter==0, go to DONE.
- DONE:
  - `out_valid`=1 and `out_bcd` is stable.
  - On `out_ready`, go to IDLE.
- `in_valid` outside IDLE is ignored. The operand is not re-sampled, so `in_result` may change freely after acceptance.
- Add-3 arithmetic is per 4-bit digit and never carries between digits. The largest input, 2^64−1, yields 18446744073709551615 with no overflow.
- `out_ndigits` gives the index of the most significant nonzero digit, plus 1. A value of 0 gives 1.
- Reset, including mid-CONV or mid-DONE:
  - State returns to IDLE.
  - `out_bcd`=0, `out_valid`=0, `in_ready`=1 from the first cycle after the sampled-low edge.
  - Any in-flight conversion is discarded.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_bcd`=0, `out_ndigits`=1.
- Acceptance at edge k:
  - `in_ready` drops after edge k.
  - The 64 iterations occur at edges k+1..k+64.
  - `out_valid` rises after edge k+64, so latency is 64 cycles from acceptance.
- `out_valid` holds with `out_bcd` stable until the edge at which `out_ready`=1.
- `in_ready` returns one cycle after the output handshake. Minimum throughput is one conversion per 66 cycles.
- `out_ready` may be held high permanently. DONE then lasts exactly one cycle.
- `ucore_main` holds `done` high until its requester drops `valid`. Because the converter accepts only in IDLE and re-arms after output, a still-high `done` after return to IDLE is accepted again. The upstream requester must drop `valid` within 65 cycles of `done`, otherwise duplicate conversions occur (accepted limitation).

## Configuration
- `UCORE_BCD_NDIGITS_EN` defined:
  - `out_ndigits` port and its register are present.
  - `out_ndigits` is computed by a priority encoder over `out_bcd` at the CONV→DONE transition and is valid with `out_valid`.
- Undefined: the port and its logic are removed; all other behaviour and timing are identical.

## Structure
- Package `ucore_bcd_pkg`:
  - FSM state encoding (IDLE/CONV/DONE).
  - `W_BIN`/`N_DIG` defaults.
  - `CNT_W`=6.
  - The digit-width constant 4.
- Sub-module `ucore_bcd_digit_adj`: combinational 4-bit "if ≥5 add 3" cell, instanced N_DIG times via generate.
- The top level holds the FSM, counter, shift register and optional digit-count encoder.

## Test plan
- `in_result`=0 → `out_bcd`=0x0, `out_ndigits`=1, `out_valid` exactly 64 cycles after acceptance.
- `in_result`=55 (fib 10) → `out_bcd`=0x55, `out_ndigits`=2; `in_result`=12586269025 (fib 50) → `out_bcd`=0x12586269025, `out_ndigits`=11.
- `in_result`=2^64−1 → `out_bcd`=0x18446744073709551615, `out_ndigits`=20.
- Backpressure: `out_ready` held low 10 cycles after `out_valid` → `out_bcd` unchanged, `in_ready`=0 throughout; `out_ready`=1 → `in_ready`=1 next cycle.
- `in_valid` pulsed with 7 mid-CONV, then `aresetn` low at iteration 30 → outputs at reset values next cycle; a fresh operand 89 converts to 0x89.
- Chained with `ucore_main` for n=1..90: every `out_bcd` matches the decimal Fibonacci golden model.
